sc_lives_levels_counter: RTL and testbench

SC_LIVES_LEVELS_COUNTER -- requirements
Module: sc_lives_levels_counter

---
 rtl/sc_lives_levels_counter.sv | 131 +++++++++++++
 tb/tb_sc_lives_levels_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_lives_levels_counter.sv
// Lives/level bookkeeping for the game state machine: falling-edge request
// detection, saturating counters and a PLAY/GAMEOVER/WIN state register.
module sc_lives_levels_counter #(
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned LEVEL_MAX  = 3,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                 SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic                 SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic                 SC_LIVES_LEVELS_COUNTER_contador_vidas_InLow,
  input  logic                 SC_LIVES_LEVELS_COUNTER_contador_niveles_InLow,
  input  logic                 SC_LIVES_LEVELS_COUNTER_clear_InLow,
  output logic [CNT_WIDTH-1:0] SC_LIVES_LEVELS_COUNTER_lives_Out,
  output logic [CNT_WIDTH-1:0] SC_LIVES_LEVELS_COUNTER_level_Out,
  output logic                 SC_LIVES_LEVELS_COUNTER_COMPARATOR_LIVES_Out,
  output logic                 SC_LIVES_LEVELS_COUNTER_COMPARATOR_LEVELS_Out,
  output logic                 SC_LIVES_LEVELS_COUNTER_event_ack_Out
);

  localparam logic [CNT_WIDTH-1:0] LIVES_INIT_C = CNT_WIDTH'(LIVES_INIT);
  localparam logic [CNT_WIDTH-1:0] LEVEL_MAX_C  = CNT_WIDTH'(LEVEL_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE_C        = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_GAMEOVER,
    ST_WIN
  } state_t;

  logic clk;
  logic rst;
  logic clr_n;

  assign clk   = SC_STATEMACHINEGENERAL_CLOCK_50;
  assign rst   = SC_STATEMACHINEGENERAL_RESET_InHigh;
  assign clr_n = SC_LIVES_LEVELS_COUNTER_clear_InLow;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] lives_q, lives_d;
  logic [CNT_WIDTH-1:0] level_q, level_d;
  logic                 ack_q, ack_d;

  // Per request: sample (s), previous sample (h), and a block flag that
  // suppresses a request already held low across a clear until it rises.
  logic vid_s_q, vid_h_q, vid_blk_q;
  logic niv_s_q, niv_h_q, niv_blk_q;
  logic life_ev, level_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_s_q   <= 1'b1;
      vid_h_q   <= 1'b1;
      vid_blk_q <= 1'b0;
      niv_s_q   <= 1'b1;
      niv_h_q   <= 1'b1;
      niv_blk_q <= 1'b0;
    end else if (!clr_n) begin
      vid_s_q   <= 1'b1;
      vid_h_q   <= 1'b1;
      vid_blk_q <= ~SC_LIVES_LEVELS_COUNTER_contador_vidas_InLow;
      niv_s_q   <= 1'b1;
      niv_h_q   <= 1'b1;
      niv_blk_q <= ~SC_LIVES_LEVELS_COUNTER_contador_niveles_InLow;
    end else begin
      vid_s_q   <= SC_LIVES_LEVELS_COUNTER_contador_vidas_InLow;
      vid_h_q   <= vid_s_q;
      vid_blk_q <= vid_blk_q & ~SC_LIVES_LEVELS_COUNTER_contador_vidas_InLow;
      niv_s_q   <= SC_LIVES_LEVELS_COUNTER_contador_niveles_InLow;
      niv_h_q   <= niv_s_q;
      niv_blk_q <= niv_blk_q & ~SC_LIVES_LEVELS_COUNTER_contador_niveles_InLow;
    end
  end

  assign life_ev  = vid_h_q & ~vid_s_q & ~vid_blk_q;
  assign level_ev = niv_h_q & ~niv_s_q & ~niv_blk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PLAY;
      lives_q <= LIVES_INIT_C;
      level_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    ack_d   = 1'b0;
    if (!clr_n) begin
      state_d = ST_PLAY;
      lives_d = LIVES_INIT_C;
      level_d = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          // Life loss wins a same-cycle collision; the level-up is dropped.
          if (life_ev) begin
            if (lives_q != '0) begin
              lives_d = lives_q - ONE_C;
              ack_d   = 1'b1;
              if (lives_q == ONE_C) state_d = ST_GAMEOVER;
            end
          end else if (level_ev) begin
            if (level_q != LEVEL_MAX_C) begin
              level_d = level_q + ONE_C;
              ack_d   = 1'b1;
              if (level_q + ONE_C == LEVEL_MAX_C) state_d = ST_WIN;
            end
          end
        end
        ST_GAMEOVER: state_d = ST_GAMEOVER;
        ST_WIN:      state_d = ST_WIN;
        default:     state_d = ST_PLAY;
      endcase
    end
  end

  assign SC_LIVES_LEVELS_COUNTER_lives_Out             = lives_q;
  assign SC_LIVES_LEVELS_COUNTER_level_Out             = level_q;
  assign SC_LIVES_LEVELS_COUNTER_COMPARATOR_LIVES_Out  = (lives_q == '0);
  assign SC_LIVES_LEVELS_COUNTER_COMPARATOR_LEVELS_Out = (level_q == LEVEL_MAX_C);
  assign SC_LIVES_LEVELS_COUNTER_event_ack_Out         = ack_q;

endmodule

// File: tb/tb_sc_lives_levels_counter.sv
// Directed self-checking bench for sc_lives_levels_counter (default parameters).
module tb_sc_lives_levels_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       vid;
  logic       niv;
  logic       clr;
  logic [2:0] lives;
  logic [2:0] level;
  logic       cmp_l;
  logic       cmp_v;
  logic       ack;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int a0;

  always #5 clk = ~clk;

  sc_lives_levels_counter #(
    .LIVES_INIT(3),
    .LEVEL_MAX (3),
    .CNT_WIDTH (3)
  ) dut (
    .SC_STATEMACHINEGENERAL_CLOCK_50               (clk),
    .SC_STATEMACHINEGENERAL_RESET_InHigh           (rst),
    .SC_LIVES_LEVELS_COUNTER_contador_vidas_InLow  (vid),
    .SC_LIVES_LEVELS_COUNTER_contador_niveles_InLow(niv),
    .SC_LIVES_LEVELS_COUNTER_clear_InLow           (clr),
    .SC_LIVES_LEVELS_COUNTER_lives_Out             (lives),
    .SC_LIVES_LEVELS_COUNTER_level_Out             (level),
    .SC_LIVES_LEVELS_COUNTER_COMPARATOR_LIVES_Out  (cmp_l),
    .SC_LIVES_LEVELS_COUNTER_COMPARATOR_LEVELS_Out (cmp_v),
    .SC_LIVES_LEVELS_COUNTER_event_ack_Out         (ack)
  );

  always @(negedge clk) if (ack === 1'b1) ack_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle low strobe; returns just after the edge where the counter updates.
  task automatic strobe(input bit life, input bit lvl);
    if (life) vid = 1'b0;
    if (lvl)  niv = 1'b0;
    tick();
    vid = 1'b1;
    niv = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; vid = 1'b1; niv = 1'b1; clr = 1'b1;
    #2;
    chk("rst_lives", lives, 3);
    chk("rst_level", level, 0);
    chk("rst_ack",   ack,   0);
    chk("rst_cmp_l", cmp_l, 0);
    chk("rst_cmp_v", cmp_v, 0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Three life-loss strobes, four cycles apart, then one more at zero
    strobe(1, 0);
    chk("life1_lives", lives, 2);
    chk("life1_ack",   ack,   1);
    chk("life1_cmp_l", cmp_l, 0);
    tick();
    chk("life1_ack_off", ack, 0);
    tick();
    strobe(1, 0);
    chk("life2_lives", lives, 1);
    idle(2);
    strobe(1, 0);
    chk("life3_lives", lives, 0);
    chk("life3_ack",   ack,   1);
    chk("life3_cmp_l", cmp_l, 1);
    idle(2);
    strobe(1, 0);
    chk("life4_lives", lives, 0);
    chk("life4_ack",   ack,   0);
    idle(2);

    // Clear from GAMEOVER with life-loss held low throughout
    a0 = ack_cnt;
    vid = 1'b0;
    tick();
    clr = 1'b0;
    tick();
    clr = 1'b1;
    chk("clr_lives", lives, 3);
    chk("clr_level", level, 0);
    chk("clr_cmp_l", cmp_l, 0);
    chk("clr_cmp_v", cmp_v, 0);
    idle(5);
    chk("clr_held_lives", lives, 3);
    chk("clr_held_acks", ack_cnt - a0, 0);
    vid = 1'b1;
    idle(2);

    // Level-up held low for 20 cycles counts once, two clocks after the fall
    a0 = ack_cnt;
    niv = 1'b0;
    tick();
    chk("hold_lat_level", level, 0);
    tick();
    chk("hold_level", level, 1);
    chk("hold_ack",   ack,   1);
    idle(18);
    chk("hold_level_end", level, 1);
    chk("hold_acks", ack_cnt - a0, 1);
    niv = 1'b1;
    idle(2);

    // Simultaneous falls: life loss wins, level-up discarded
    a0 = ack_cnt;
    strobe(1, 1);
    chk("both_lives", lives, 2);
    chk("both_level", level, 1);
    chk("both_ack",   ack,   1);
    idle(3);
    chk("both_acks", ack_cnt - a0, 1);
    chk("both_level_late", level, 1);

    // Clear beats an event pending at the same edge
    vid = 1'b0;
    tick();
    vid = 1'b1;
    clr = 1'b0;
    tick();
    clr = 1'b1;
    chk("clrpri_lives", lives, 3);
    chk("clrpri_level", level, 0);
    chk("clrpri_ack",   ack,   0);
    idle(2);

    // Three level-ups reach WIN; further events ignored
    strobe(0, 1);
    chk("lvl1_level", level, 1);
    chk("lvl1_ack",   ack,   1);
    idle(2);
    strobe(0, 1);
    chk("lvl2_level", level, 2);
    chk("lvl2_cmp_v", cmp_v, 0);
    idle(2);
    strobe(0, 1);
    chk("lvl3_level", level, 3);
    chk("lvl3_cmp_v", cmp_v, 1);
    chk("lvl3_ack",   ack,   1);
    idle(2);
    a0 = ack_cnt;
    strobe(1, 0);
    chk("win_life_lives", lives, 3);
    idle(2);
    strobe(0, 1);
    chk("win_lvl_level", level, 3);
    idle(2);
    chk("win_acks", ack_cnt - a0, 0);

    // Reset one cycle after a life-loss fall discards the pending update
    clr = 1'b0;
    tick();
    clr = 1'b1;
    idle(2);
    a0 = ack_cnt;
    vid = 1'b0;
    tick();
    vid = 1'b1;
    rst = 1'b1;
    #1;
    chk("rstmid_lives", lives, 3);
    chk("rstmid_ack",   ack,   0);
    idle(2);
    rst = 1'b0;
    idle(4);
    chk("rstmid_lives_after", lives, 3);
    chk("rstmid_acks", ack_cnt - a0, 0);

    // Request low at reset release: recognised at the second edge, not the first
    rst = 1'b1;
    tick();
    vid = 1'b0;
    rst = 1'b0;
    tick();
    chk("postrst_edge1_lives", lives, 3);
    tick();
    chk("postrst_edge2_lives", lives, 2);
    vid = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
